mem_stage_ctrl: RTL

//  Parametrised MEM stage for the pipelined RISC-V core, sitting between EX and WB.

---
 rtl/mem_stage_ctrl_pkg.sv | 44 ++++
 rtl/mem_stage_ctrl_if.sv | 25 ++
 rtl/mem_stage_ctrl_load_align.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, exception codes,
// FSM state type and the byte-enable helper.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10,
        EXC_ILLEGAL  = 2'b11
    } exc_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    // Byte-enable mask for an access of 2**size bytes at byte offset off
    // within an 8-byte lane group; callers keep the low XLEN/8 bits.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/grant/rvalid bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic                dmem_req;
    logic                dmem_we;
    logic [ADDR_W-1:0]   dmem_addr;
    logic [XLEN/8-1:0]   dmem_be;
    logic [XLEN-1:0]     dmem_wdata;
    logic                dmem_gnt;
    logic                dmem_rvalid;
    logic [XLEN-1:0]     dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl_load_align.sv
// Combinational load aligner: selects the byte/half/word lane addressed by the
// low address bits and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]          i_rdata,
    input  logic [$clog2(XLEN/8)-1:0] i_off,
    input  logic [2:0]               i_funct3,
    output logic [XLEN-1:0]          o_data
);
    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_funct3)
            F3_LB:   o_data = XLEN'($signed(w_shifted[7:0]));
            F3_LH:   o_data = XLEN'($signed(w_shifted[15:0]));
            F3_LW:   o_data = XLEN'($signed(w_shifted[31:0]));
            F3_LBU:  o_data = XLEN'(w_shifted[7:0]);
            F3_LHU:  o_data = XLEN'(w_shifted[15:0]);
            F3_LWU:  o_data = XLEN'(w_shifted[31:0]);
            default: o_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: accepts EX ops, runs loads/stores over the dmem bus with
// timeout and flush handling, and holds one registered result for WB.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [2:0]        funct3_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              regwrite_i,
    input  logic [4:0]        rd_i,
    mem_stage_ctrl_if.master  dmem,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [4:0]        wb_rd_o,
    output logic              wb_regwrite_o,
    output logic [1:0]        wb_exc_o
);
    localparam int NB       = XLEN / 8;
    localparam int OFF_W    = $clog2(NB);
    localparam int CNT_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TMO_LAST = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_drop;
    logic [2:0]          r_funct3;
    logic [OFF_W-1:0]    r_off;
    logic [4:0]          r_rd;
    logic                r_regwrite;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [NB-1:0]       r_be;
    logic [XLEN-1:0]     r_wdata;
    logic                r_wb_valid;
    logic [XLEN-1:0]     r_wb_data;
    logic [4:0]          r_wb_rd;
    logic                r_wb_regwrite;
    exc_e                r_wb_exc;

    logic                w_accept;
    logic                w_is_mem;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_tmo_hit;
    logic [OFF_W-1:0]    w_off;
    logic [7:0]          w_be8;
    logic [NB-1:0]       w_be;
    logic [ADDR_W-1:0]   w_addr;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_load_data;
    logic                w_res_fire;
    logic [XLEN-1:0]     w_res_data;
    logic                w_res_regwrite;
    exc_e                w_res_exc;
    logic [4:0]          w_res_rd;

    assign ex_ready_o = (r_state == IDLE) & (~r_wb_valid | wb_ready_i) & ~r_drop;
    assign w_accept   = ex_valid_i & ex_ready_o & ~flush_i;
    assign w_is_mem   = memread_i | memwrite_i;
    assign w_off      = alu_result_i[OFF_W-1:0];
    assign w_be8      = byte_en(funct3_i[1:0], 3'(w_off));
    assign w_be       = w_be8[NB-1:0];
    assign w_addr     = {alu_result_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TMO_LAST));

    // Store data is replicated so every lane carries the value the enables select.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_wdata[gi*8 +: 8] =
                (funct3_i[1:0] == 2'd0) ? store_data_i[7:0] :
                (funct3_i[1:0] == 2'd1) ? store_data_i[(gi % 2)*8 +: 8] :
                (funct3_i[1:0] == 2'd2) ? store_data_i[(gi % 4)*8 +: 8] :
                                          store_data_i[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        case (funct3_i[1:0])
            2'd1:    w_misalign = alu_result_i[0];
            2'd2:    w_misalign = |alu_result_i[1:0];
            2'd3:    w_misalign = |alu_result_i[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_illegal = 1'b0;
        if (memread_i)
            w_illegal = (funct3_i == 3'b111) ||
                        ((XLEN == 32) && (funct3_i == F3_LD || funct3_i == F3_LWU));
        else if (memwrite_i)
            w_illegal = funct3_i[2] || ((XLEN == 32) && (funct3_i == F3_SD));
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (dmem.dmem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    // Result selection; flush suppresses any result produced in the same cycle.
    always_comb begin
        w_res_fire     = 1'b0;
        w_res_data     = '0;
        w_res_regwrite = 1'b0;
        w_res_exc      = EXC_NONE;
        w_res_rd       = r_rd;
        case (r_state)
            IDLE: begin
                w_res_rd   = rd_i;
                w_res_data = alu_result_i;
                if (w_accept) begin
                    if (!w_is_mem) begin
                        w_res_fire     = 1'b1;
                        w_res_regwrite = regwrite_i;
                    end else if (w_illegal) begin
                        w_res_fire = 1'b1;
                        w_res_exc  = EXC_ILLEGAL;
                    end else if (w_misalign) begin
                        w_res_fire = 1'b1;
                        w_res_exc  = EXC_MISALIGN;
                    end
                end
            end
            REQ: begin
                if (!flush_i) begin
                    if (dmem.dmem_gnt) begin
                        if (r_we) begin
                            w_res_fire = 1'b1;
                        end else if (dmem.dmem_rvalid) begin
                            w_res_fire     = 1'b1;
                            w_res_data     = w_load_data;
                            w_res_regwrite = r_regwrite;
                        end
                    end else if (w_tmo_hit) begin
                        w_res_fire = 1'b1;
                        w_res_exc  = EXC_TIMEOUT;
                    end
                end
            end
            WAIT_R: begin
                if (!flush_i) begin
                    if (dmem.dmem_rvalid) begin
                        w_res_fire     = 1'b1;
                        w_res_data     = w_load_data;
                        w_res_regwrite = r_regwrite;
                    end else if (w_tmo_hit) begin
                        w_res_fire = 1'b1;
                        w_res_exc  = EXC_TIMEOUT;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_drop        <= 1'b0;
            r_funct3      <= '0;
            r_off         <= '0;
            r_rd          <= '0;
            r_regwrite    <= 1'b0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_wb_rd       <= '0;
            r_wb_regwrite <= 1'b0;
            r_wb_exc      <= EXC_NONE;
        end else begin
            if (flush_i) begin
                r_wb_valid <= 1'b0;
            end else if (w_res_fire) begin
                r_wb_valid    <= 1'b1;
                r_wb_data     <= w_res_data;
                r_wb_rd       <= w_res_rd;
                r_wb_regwrite <= w_res_regwrite;
                r_wb_exc      <= w_res_exc;
            end else if (r_wb_valid && wb_ready_i) begin
                r_wb_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // An orphaned read is still owed by the bus; wait for it or give up.
                    if (r_drop) begin
                        if (dmem.dmem_rvalid || w_tmo_hit) begin
                            r_drop <= 1'b0;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    if (w_accept) begin
                        r_funct3   <= funct3_i;
                        r_off      <= w_off;
                        r_rd       <= rd_i;
                        r_regwrite <= regwrite_i;
                        if (w_is_mem && !w_illegal && !w_misalign) begin
                            r_state <= REQ;
                            r_req   <= 1'b1;
                            r_we    <= memwrite_i & ~memread_i;
                            r_addr  <= w_addr;
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_cnt   <= '0;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        if (dmem.dmem_gnt && !r_we && !dmem.dmem_rvalid) begin
                            r_drop <= 1'b1;
                            r_cnt  <= '0;
                        end
                    end else if (dmem.dmem_gnt) begin
                        r_req <= 1'b0;
                        r_cnt <= '0;
                        r_state <= (r_we || dmem.dmem_rvalid) ? IDLE : WAIT_R;
                    end else if (w_tmo_hit) begin
                        r_req   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_R: begin
                    if (dmem.dmem_rvalid) begin
                        r_state <= IDLE;
                    end else if (flush_i || w_tmo_hit) begin
                        r_state <= IDLE;
                        r_drop  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

    assign wb_valid_o    = r_wb_valid;
    assign wb_data_o     = r_wb_data;
    assign wb_rd_o       = r_wb_rd;
    assign wb_regwrite_o = r_wb_regwrite;
    assign wb_exc_o      = r_wb_exc;
endmodule
